global_ldst_ctrl: RTL

// Handshake controller beside global_ldst: joins the per-group AXI valid/ready handshakes into one system transaction.

---
 rtl/global_ldst_ctrl_if.sv | 45 ++++
 rtl/global_ldst_ctrl.sv | 93 +++++++++
 2 files changed

// File: rtl/global_ldst_ctrl_if.sv
// Valid/ready bundle between the lane groups, the system AXI port and global_ldst_ctrl.
// The controller takes the slave side; the groups and system port together form the master side.
interface global_ldst_ctrl_if #(
    parameter int NrGroups = 4
);
    logic [NrGroups-1:0] grp_ar_valid_i;
    logic [NrGroups-1:0] grp_ar_ready_o;
    logic [NrGroups-1:0] grp_aw_valid_i;
    logic [NrGroups-1:0] grp_aw_ready_o;
    logic [NrGroups-1:0] grp_w_valid_i;
    logic [NrGroups-1:0] grp_w_last_i;
    logic [NrGroups-1:0] grp_w_ready_o;
    logic [NrGroups-1:0] grp_r_valid_o;
    logic [NrGroups-1:0] grp_r_ready_i;
    logic [NrGroups-1:0] grp_b_valid_o;
    logic [NrGroups-1:0] grp_b_ready_i;
    logic                ar_valid_o;
    logic                ar_ready_i;
    logic                aw_valid_o;
    logic                aw_ready_i;
    logic                w_valid_o;
    logic                w_last_o;
    logic                w_ready_i;
    logic                r_valid_i;
    logic                r_last_i;
    logic                r_ready_o;
    logic                b_valid_i;
    logic                b_ready_o;

    modport slave (
        input  grp_ar_valid_i, grp_aw_valid_i, grp_w_valid_i, grp_w_last_i,
        input  grp_r_ready_i, grp_b_ready_i,
        input  ar_ready_i, aw_ready_i, w_ready_i, r_valid_i, r_last_i, b_valid_i,
        output grp_ar_ready_o, grp_aw_ready_o, grp_w_ready_o, grp_r_valid_o, grp_b_valid_o,
        output ar_valid_o, aw_valid_o, w_valid_o, w_last_o, r_ready_o, b_ready_o
    );

    modport master (
        output grp_ar_valid_i, grp_aw_valid_i, grp_w_valid_i, grp_w_last_i,
        output grp_r_ready_i, grp_b_ready_i,
        output ar_ready_i, aw_ready_i, w_ready_i, r_valid_i, r_last_i, b_valid_i,
        input  grp_ar_ready_o, grp_aw_ready_o, grp_w_ready_o, grp_r_valid_o, grp_b_valid_o,
        input  ar_valid_o, aw_valid_o, w_valid_o, w_last_o, r_ready_o, b_ready_o
    );
endinterface

// File: rtl/global_ldst_ctrl.sv
// Joins per-group AXI valid/ready handshakes into one system transaction and broadcasts
// R/B beats back so every group accepts each beat exactly once; tracks outstanding bursts.
module global_ldst_ctrl #(
    parameter int NrGroups       = 4,
    parameter int MaxOutstanding = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    global_ldst_ctrl_if.slave    bus,
    output logic                 err_o,
    output logic                 idle_o
);
    localparam int CW = $clog2(MaxOutstanding + 1);
    localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);
    localparam logic [CW-1:0] SatCnt = {CW{1'b1}};

    logic [CW-1:0]       r_ar_cnt, r_aw_cnt, r_wb_cnt;
    logic [NrGroups-1:0] r_r_taken, r_b_taken;
    logic                r_err;

    logic                w_ar_fire, w_aw_fire, w_w_fire, w_r_fire, w_b_fire;
    logic                w_w_mismatch;
    logic [CW:0]         w_ar_step, w_aw_step, w_wb_step;
    logic [NrGroups-1:0] w_r_taken_nxt, w_b_taken_nxt;

    // Returns {underflow, next count}; a dec at zero is dropped and reported instead.
    function automatic logic [CW:0] cnt_step(input logic [CW-1:0] cnt, input logic inc,
                                              input logic dec, input logic [CW-1:0] top);
        logic [CW-1:0] nxt;
        logic          uf;
        nxt = cnt;
        uf  = 1'b0;
        if (inc && !dec && cnt != top) begin
            nxt = cnt + CW'(1);
        end else if (dec && !inc) begin
            if (cnt == '0) uf = 1'b1;
            else           nxt = cnt - CW'(1);
        end
        return {uf, nxt};
    endfunction

    assign bus.ar_valid_o     = (&bus.grp_ar_valid_i) & (r_ar_cnt < MaxCnt);
    assign bus.aw_valid_o     = (&bus.grp_aw_valid_i) & (r_aw_cnt < MaxCnt);
    assign w_ar_fire          = bus.ar_valid_o & bus.ar_ready_i;
    assign w_aw_fire          = bus.aw_valid_o & bus.aw_ready_i;
    assign bus.grp_ar_ready_o = {NrGroups{w_ar_fire}};
    assign bus.grp_aw_ready_o = {NrGroups{w_aw_fire}};

    // Registered wb_cnt means an AW firing this cycle opens W only from the next cycle.
    assign bus.w_valid_o      = (&bus.grp_w_valid_i) & (r_wb_cnt != '0);
    assign bus.w_last_o       = bus.grp_w_last_i[0];
    assign w_w_fire           = bus.w_valid_o & bus.w_ready_i;
    assign bus.grp_w_ready_o  = {NrGroups{w_w_fire}};
    assign w_w_mismatch       = w_w_fire & (bus.grp_w_last_i != '0) & (bus.grp_w_last_i != '1);

    assign bus.grp_r_valid_o  = {NrGroups{bus.r_valid_i}} & ~r_r_taken;
    assign bus.r_ready_o      = &(r_r_taken | bus.grp_r_ready_i);
    assign w_r_fire           = bus.r_valid_i & bus.r_ready_o;
    assign w_r_taken_nxt      = bus.r_ready_o ? '0
                              : (r_r_taken | (bus.grp_r_valid_o & bus.grp_r_ready_i));

    assign bus.grp_b_valid_o  = {NrGroups{bus.b_valid_i}} & ~r_b_taken;
    assign bus.b_ready_o      = &(r_b_taken | bus.grp_b_ready_i);
    assign w_b_fire           = bus.b_valid_i & bus.b_ready_o;
    assign w_b_taken_nxt      = bus.b_ready_o ? '0
                              : (r_b_taken | (bus.grp_b_valid_o & bus.grp_b_ready_i));

    assign w_ar_step = cnt_step(r_ar_cnt, w_ar_fire, w_r_fire & bus.r_last_i, MaxCnt);
    assign w_aw_step = cnt_step(r_aw_cnt, w_aw_fire, w_b_fire, MaxCnt);
    assign w_wb_step = cnt_step(r_wb_cnt, w_aw_fire, w_w_fire & bus.w_last_o, SatCnt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ar_cnt  <= '0;
            r_aw_cnt  <= '0;
            r_wb_cnt  <= '0;
            r_r_taken <= '0;
            r_b_taken <= '0;
            r_err     <= 1'b0;
        end else begin
            r_ar_cnt  <= w_ar_step[CW-1:0];
            r_aw_cnt  <= w_aw_step[CW-1:0];
            r_wb_cnt  <= w_wb_step[CW-1:0];
            r_r_taken <= w_r_taken_nxt;
            r_b_taken <= w_b_taken_nxt;
            r_err     <= r_err | w_w_mismatch | w_ar_step[CW] | w_aw_step[CW] | w_wb_step[CW];
        end
    end

    assign err_o  = r_err;
    assign idle_o = (r_ar_cnt == '0) & (r_aw_cnt == '0) & (r_wb_cnt == '0)
                  & ~|r_r_taken & ~|r_b_taken;
endmodule
